ex_operand_stage: RTL

- ID/EX pipeline slot that sits directly upstream of the integer ALU.
- Captures one decoded instruction per valid/ready handshake, resolves RAW hazards by forwarding from the MEM and WB stages, and inserts bubbles on load-use hazards.
- Drives the ALU operands a, b and op, plus the metadata the EX/MEM register needs.
- Refreshes held operands every stall cycle so forwarded values are never lost.

---
 rtl/ex_operand_stage_pkg.sv | 30 +++
 rtl/ex_operand_stage_fwd_mux.sv | 39 +++
 rtl/ex_operand_stage.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ex_operand_stage_pkg.sv
// Package: ex_operand_stage_pkg
// Purpose: operand-select encodings and ALU op codes shared by the operand
//          stage, its forwarding mux and the ALU.
// Contents: A_SEL_* (2-bit operand-A source), B_SEL_* (1-bit operand-B
//           source), ALU_* operation codes (ALU_OP_W bits).
package ex_operand_stage_pkg;

  // Operand-A source select.
  localparam logic [1:0] A_SEL_RS1  = 2'b00;
  localparam logic [1:0] A_SEL_PC   = 2'b01;
  localparam logic [1:0] A_SEL_ZERO = 2'b10;  // 2'b11 is reserved and also yields zero

  // Operand-B source select.
  localparam logic       B_SEL_RS2  = 1'b0;
  localparam logic       B_SEL_IMM  = 1'b1;

  // ALU operation codes; the ALU decodes these, this stage only carries them.
  localparam int         ALU_OP_W   = 5;
  localparam logic [4:0] ALU_ADD    = 5'd0;
  localparam logic [4:0] ALU_SUB    = 5'd1;
  localparam logic [4:0] ALU_AND    = 5'd2;
  localparam logic [4:0] ALU_OR     = 5'd3;
  localparam logic [4:0] ALU_XOR    = 5'd4;
  localparam logic [4:0] ALU_SLL    = 5'd5;
  localparam logic [4:0] ALU_SRL    = 5'd6;
  localparam logic [4:0] ALU_SRA    = 5'd7;
  localparam logic [4:0] ALU_SLT    = 5'd8;
  localparam logic [4:0] ALU_SLTU   = 5'd9;

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Module: ex_operand_stage_fwd_mux
// Purpose: combinational RAW-forwarding resolution for one source operand.
//          x0 always reads zero; MEM-stage results take priority over WB.
// Ports:
//   i_idx       source register index
//   i_data      fallback (register-file or held) value
//   i_mem_we/i_mem_rd/i_mem_data   MEM-stage result
//   i_wb_we/i_wb_rd/i_wb_data      WB-stage result
//   o_data      resolved operand value
module ex_operand_stage_fwd_mux #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] i_idx,
  input  logic [WIDTH-1:0]      i_data,
  input  logic                  i_mem_we,
  input  logic [REG_ADDR_W-1:0] i_mem_rd,
  input  logic [WIDTH-1:0]      i_mem_data,
  input  logic                  i_wb_we,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  input  logic [WIDTH-1:0]      i_wb_data,
  output logic [WIDTH-1:0]      o_data
);

  // Priority select: zero register, then MEM, then WB, then fallback.
  always_comb begin
    o_data = i_data;
    if (i_idx == {REG_ADDR_W{1'b0}}) begin
      o_data = {WIDTH{1'b0}};
    end else if (i_mem_we && (i_mem_rd == i_idx)) begin
      o_data = i_mem_data;
    end else if (i_wb_we && (i_wb_rd == i_idx)) begin
      o_data = i_wb_data;
    end else begin
      o_data = i_data;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// Module: ex_operand_stage
// Purpose: ID/EX slot in front of the integer ALU. Captures one decoded
//          instruction per valid/ready handshake, forwards from MEM/WB,
//          inserts bubbles on load-use hazards and refreshes held operands
//          on every stall cycle.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          upstream handshake
//   in_pc, in_rs1_data, in_rs2_data, in_rs1, in_rs2, in_rd, in_imm,
//   in_op, in_a_sel, in_b_sel, in_rd_we    decoded instruction fields
//   flush                      synchronous kill of slot and incoming instr
//   mem_fwd_*, wb_fwd_*        forwarding sources (mem_fwd_pending = load)
//   out_valid/out_ready        downstream handshake
//   alu_a, alu_b, alu_op       ALU operands and operation
//   out_pc, out_store_data, out_rd, out_rd_we   EX/MEM metadata
module ex_operand_stage
  import ex_operand_stage_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int ALU_OP_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_pc,
  input  logic [WIDTH-1:0]        in_rs1_data,
  input  logic [WIDTH-1:0]        in_rs2_data,
  input  logic [REG_ADDR_W-1:0]   in_rs1,
  input  logic [REG_ADDR_W-1:0]   in_rs2,
  input  logic [REG_ADDR_W-1:0]   in_rd,
  input  logic [WIDTH-1:0]        in_imm,
  input  logic [ALU_OP_WIDTH-1:0] in_op,
  input  logic [1:0]              in_a_sel,
  input  logic                    in_b_sel,
  input  logic                    in_rd_we,
  input  logic                    flush,
  input  logic                    mem_fwd_we,
  input  logic [REG_ADDR_W-1:0]   mem_fwd_rd,
  input  logic [WIDTH-1:0]        mem_fwd_data,
  input  logic                    mem_fwd_pending,
  input  logic                    wb_fwd_we,
  input  logic [REG_ADDR_W-1:0]   wb_fwd_rd,
  input  logic [WIDTH-1:0]        wb_fwd_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        alu_a,
  output logic [WIDTH-1:0]        alu_b,
  output logic [ALU_OP_WIDTH-1:0] alu_op,
  output logic [WIDTH-1:0]        out_pc,
  output logic [WIDTH-1:0]        out_store_data,
  output logic [REG_ADDR_W-1:0]   out_rd,
  output logic                    out_rd_we
);

  logic                    r_valid;
  logic [WIDTH-1:0]        r_pc;
  logic [WIDTH-1:0]        r_rs1_data;
  logic [WIDTH-1:0]        r_rs2_data;
  logic [REG_ADDR_W-1:0]   r_rs1;
  logic [REG_ADDR_W-1:0]   r_rs2;
  logic [REG_ADDR_W-1:0]   r_rd;
  logic [WIDTH-1:0]        r_imm;
  logic [ALU_OP_WIDTH-1:0] r_op;
  logic [1:0]              r_a_sel;
  logic                    r_b_sel;
  logic                    r_rd_we;

  logic [WIDTH-1:0]        w_rs1_res;   // resolved held rs1: outputs and hold refresh
  logic [WIDTH-1:0]        w_rs2_res;
  logic [WIDTH-1:0]        w_rs1_in;    // resolved incoming rs1: capture path
  logic [WIDTH-1:0]        w_rs2_in;
  logic                    w_hazard;
  logic                    w_fire;
  logic                    w_capture;

  // On a back-to-back transfer the held instruction drives the ALU while the
  // next one is captured, so held and incoming operands are resolved in
  // parallel rather than through one shared pre-muxed resolver.
  ex_operand_stage_fwd_mux #(.WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1_q (
    .i_idx(r_rs1), .i_data(r_rs1_data),
    .i_mem_we(mem_fwd_we), .i_mem_rd(mem_fwd_rd), .i_mem_data(mem_fwd_data),
    .i_wb_we(wb_fwd_we), .i_wb_rd(wb_fwd_rd), .i_wb_data(wb_fwd_data),
    .o_data(w_rs1_res)
  );

  ex_operand_stage_fwd_mux #(.WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2_q (
    .i_idx(r_rs2), .i_data(r_rs2_data),
    .i_mem_we(mem_fwd_we), .i_mem_rd(mem_fwd_rd), .i_mem_data(mem_fwd_data),
    .i_wb_we(wb_fwd_we), .i_wb_rd(wb_fwd_rd), .i_wb_data(wb_fwd_data),
    .o_data(w_rs2_res)
  );

  ex_operand_stage_fwd_mux #(.WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1_in (
    .i_idx(in_rs1), .i_data(in_rs1_data),
    .i_mem_we(mem_fwd_we), .i_mem_rd(mem_fwd_rd), .i_mem_data(mem_fwd_data),
    .i_wb_we(wb_fwd_we), .i_wb_rd(wb_fwd_rd), .i_wb_data(wb_fwd_data),
    .o_data(w_rs1_in)
  );

  ex_operand_stage_fwd_mux #(.WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2_in (
    .i_idx(in_rs2), .i_data(in_rs2_data),
    .i_mem_we(mem_fwd_we), .i_mem_rd(mem_fwd_rd), .i_mem_data(mem_fwd_data),
    .i_wb_we(wb_fwd_we), .i_wb_rd(wb_fwd_rd), .i_wb_data(wb_fwd_data),
    .o_data(w_rs2_in)
  );

  // Load-use hazard: rs2 is checked regardless of b_sel because store data
  // also consumes it; rs1 only matters when it actually feeds operand A.
  assign w_hazard = r_valid && mem_fwd_we && mem_fwd_pending &&
                    (mem_fwd_rd != {REG_ADDR_W{1'b0}}) &&
                    (((mem_fwd_rd == r_rs1) && (r_a_sel == A_SEL_RS1)) ||
                     (mem_fwd_rd == r_rs2));

  assign out_valid = r_valid && !w_hazard;
  assign w_fire    = out_valid && out_ready;
  assign in_ready  = !r_valid || w_fire;
  assign w_capture = in_valid && in_ready && !flush;

  // Operand muxing toward the ALU and the EX/MEM register.
  always_comb begin
    alu_a = {WIDTH{1'b0}};
    case (r_a_sel)
      A_SEL_RS1: alu_a = w_rs1_res;
      A_SEL_PC:  alu_a = r_pc;
      default:   alu_a = {WIDTH{1'b0}};
    endcase
    if (r_b_sel == B_SEL_IMM) begin
      alu_b = r_imm;
    end else begin
      alu_b = w_rs2_res;
    end
  end

  assign out_store_data = w_rs2_res;
  assign alu_op         = r_op;
  assign out_pc         = r_pc;
  assign out_rd         = r_rd;
  assign out_rd_we      = r_rd_we;

  // Slot register: flush beats capture, capture beats drain, and a held
  // slot re-samples its resolved operands so late forwards are kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_pc       <= {WIDTH{1'b0}};
      r_rs1_data <= {WIDTH{1'b0}};
      r_rs2_data <= {WIDTH{1'b0}};
      r_rs1      <= {REG_ADDR_W{1'b0}};
      r_rs2      <= {REG_ADDR_W{1'b0}};
      r_rd       <= {REG_ADDR_W{1'b0}};
      r_imm      <= {WIDTH{1'b0}};
      r_op       <= {ALU_OP_WIDTH{1'b0}};
      r_a_sel    <= 2'b00;
      r_b_sel    <= 1'b0;
      r_rd_we    <= 1'b0;
    end else if (flush) begin
      r_valid    <= 1'b0;
    end else if (w_capture) begin
      r_valid    <= 1'b1;
      r_pc       <= in_pc;
      r_rs1_data <= w_rs1_in;
      r_rs2_data <= w_rs2_in;
      r_rs1      <= in_rs1;
      r_rs2      <= in_rs2;
      r_rd       <= in_rd;
      r_imm      <= in_imm;
      r_op       <= in_op;
      r_a_sel    <= in_a_sel;
      r_b_sel    <= in_b_sel;
      r_rd_we    <= in_rd_we;
    end else if (w_fire) begin
      r_valid    <= 1'b0;
    end else if (r_valid) begin
      r_rs1_data <= w_rs1_res;
      r_rs2_data <= w_rs2_res;
    end else begin
      r_valid    <= 1'b0;
    end
  end

endmodule
